conv5x5_mac_engine: RTL

//  Downstream consumer of the 5x5 line-buffer window: computes one 5x5 convolution per valid window.

---
 rtl/conv5x5_mac_engine.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/conv5x5_mac_engine.sv
// 5x5 convolution MAC engine: serial weight/bias load, then one convolution per kept window
// through a 4-stage pipeline (multiply, row sum, total + bias, ReLU/requantise).

module conv5x5_tap #(
    parameter int word_length = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [word_length-1:0] pixel,
    input  logic [word_length-1:0] weight,
    output logic [2*word_length:0] prod
);
    localparam int PW = 2*word_length + 1;

    logic signed [PW-1:0] px_s, wt_s;

    // Pixel is unsigned: zero-extend; weight is signed: sign-extend.
    assign px_s = {{(PW-word_length){1'b0}}, pixel};
    assign wt_s = {{(PW-word_length){weight[word_length-1]}}, weight};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     prod <= '0;
        else if (en) prod <= px_s * wt_s;
    end
endmodule

module conv5x5_mac_engine #(
    parameter int word_length = 8,
    parameter int bias_length = 16,
    parameter int acc_length  = 24,
    parameter int image_size  = 28,
    parameter int kernel_size = 5,
    parameter int shift       = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clr,
    input  logic                                     w_valid,
    input  logic [bias_length-1:0]                   w_data,
    output logic                                     w_ready,
    input  logic                                     win_valid,
    input  logic [kernel_size*kernel_size*word_length-1:0] win_flat,
    output logic                                     out_valid,
    output logic [word_length-1:0]                   out_data,
    output logic                                     frame_done
);
    localparam int NUM_TAPS   = kernel_size*kernel_size;
    localparam int PW         = 2*word_length + 1;
    localparam int RW         = PW + 3;
    localparam int STAGES     = 3;
    localparam int IW         = $clog2(NUM_TAPS+1);
    localparam int CW         = $clog2(image_size);
    localparam int FRAME_OUTS = (image_size-4)*(image_size-4);
    localparam int NW         = $clog2(FRAME_OUTS);

    localparam logic [IW-1:0] IDX_BIAS  = IW'(NUM_TAPS);
    localparam logic [CW-1:0] COL_FIRST = CW'(kernel_size-1);
    localparam logic [CW-1:0] COL_LAST  = CW'(image_size-1);
    localparam logic [NW-1:0] CNT_LAST  = NW'(FRAME_OUTS-1);
    localparam logic signed [acc_length-1:0] MAX_OUT = acc_length'((1 << word_length) - 1);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t                                  state, state_nxt;
    logic [IW-1:0]                           idx;
    logic [NUM_TAPS-1:0][word_length-1:0]    w_mem;
    logic [bias_length-1:0]                  bias;
    logic [CW-1:0]                           col, col_nxt;
    logic                                    win_d, keep, run;
    logic [STAGES:0]                         vld_pipe;
    logic [NUM_TAPS-1:0][PW-1:0]             prod;
    logic [kernel_size-1:0][RW-1:0]          row_sum, row_r;
    logic signed [acc_length-1:0]            acc_sum, acc_r, v;
    logic [word_length-1:0]                  out_nxt;
    logic [NW-1:0]                           out_cnt;

    assign run     = (state == S_RUN);
    assign w_ready = (state == S_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = S_LOAD;
        else if (state == S_LOAD && w_valid && idx == IDX_BIAS)
            state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            w_mem <= '0;
            bias  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (state == S_LOAD && w_valid) begin
            if (idx == IDX_BIAS) begin
                bias <= w_data;
                idx  <= '0;
            end else begin
                w_mem[idx] <= w_data[word_length-1:0];
                idx        <= idx + IW'(1);
            end
        end
    end

    // The first window of a burst is the one whose rightmost column is kernel_size-1.
    always_comb begin
        col_nxt = col;
        keep    = 1'b0;
        if (run && win_valid) begin
            col_nxt = !win_d ? COL_FIRST : ((col == COL_LAST) ? '0 : col + CW'(1));
            keep    = (col_nxt >= COL_FIRST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col   <= '0;
            win_d <= 1'b0;
        end else if (clr || !run) begin
            col   <= '0;
            win_d <= 1'b0;
        end else begin
            win_d <= win_valid;
            col   <= win_valid ? col_nxt : '0;
        end
    end

    // Bit s marks valid data in stage s+1; the top bit is out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_pipe <= '0;
        else if (clr) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:0], keep};
    end

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        conv5x5_tap #(.word_length(word_length)) u_tap (
            .clk    (clk),
            .rst    (rst),
            .en     (keep),
            .pixel  (win_flat[t*word_length +: word_length]),
            .weight (w_mem[t]),
            .prod   (prod[t])
        );
    end

    always_comb begin
        row_sum = '0;
        for (int r = 0; r < kernel_size; r++)
            for (int c = 0; c < kernel_size; c++)
                row_sum[r] = RW'($signed(row_sum[r]) + RW'($signed(prod[r*kernel_size+c])));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              row_r <= '0;
        else if (vld_pipe[0]) row_r <= row_sum;
    end

    always_comb begin
        acc_sum = acc_length'($signed(bias));
        for (int r = 0; r < kernel_size; r++)
            acc_sum = acc_sum + acc_length'($signed(row_r[r]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              acc_r <= '0;
        else if (vld_pipe[1]) acc_r <= acc_sum;
    end

    assign v = acc_r >>> shift;

    always_comb begin
        out_nxt = v[word_length-1:0];
        if (v[acc_length-1])  out_nxt = '0;
        else if (v > MAX_OUT) out_nxt = '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            frame_done <= 1'b0;
            out_cnt    <= '0;
        end else if (clr) begin
            frame_done <= 1'b0;
            out_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (vld_pipe[STAGES-1]) begin
                out_data   <= out_nxt;
                frame_done <= (out_cnt == CNT_LAST);
                out_cnt    <= (out_cnt == CNT_LAST) ? '0 : out_cnt + NW'(1);
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule
